ps2_keycode_rx: RTL and testbench
=================================

# ps2_keycode_rx

PS/2 keyboard receiver that deserialises device-to-host frames from the keyboard's clock/data lines, checks them, and turns the scan-code byte stream into key-level events. It tracks the E0 (extended) and F0 (break) prefixes. It presents a stable `key_code` for the currently held make code, with a one-cycle `key_valid` strobe per make. It sits directly upstream of the scan-code-to-ASCII converter, whose `key_code` input it drives; `key_code = 8'h00` means "no key held".

## Interface
- `FILTER_LEN`, 8: number of consecutive identical `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles with no filtered falling edge after which a partial frame is aborted.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2c`  in  1  raw PS/2 clock from pin (asynchronous).
- `ps2d`  in  1  raw PS/2 data from pin (asynchronous).
- `key_code`  out  8  scan code of the last make still held; 8'h00 when none.
- `key_valid`  out  1  one-cycle pulse, `key_code`/`key_ext` freshly loaded by a make.
- `key_ext`  out  1  the make in `key_code` was E0-prefixed.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Line conditioning:
  - `ps2c` and `ps2d` each pass through a 2-flop synchroniser.
  - Filtered clock changes level only after FILTER_LEN equal synchronised samples.
  - A filtered 1→0 transition is a fall edge. Data is sampled from synchronised `ps2d` on that cycle.
- Frame FSM states and transitions:
  - IDLE: on fall edge with data 0 (start bit), go to DATA. A fall edge with data 1 is ignored.
  - DATA: shift 8 bits LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: on fall edge, go to IDLE. The byte is accepted only if data=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity); otherwise pulse `frame_err` and discard the byte.
- Watchdog counter:
  - Cleared on every fall edge and while in IDLE.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state forces IDLE and pulses `frame_err`.
- Byte decoder (holds flags `brk`, `ext`), applied to each accepted byte:
  - E0: set `ext`.
  - F0: set `brk`.
  - 00, AA, EE, FA, FE, FF: ignore the byte and clear both flags.
  - Other byte B with `brk`=0 (make): load `key_code`=B and `key_ext`=`ext`; pulse `key_valid`; clear flags. Typematic repeats of the same code pulse `key_valid` again.
  - Other byte B with `brk`=1 (break): if B==`key_code` and `ext`==`key_ext`, clear `key_code` to 00 and `key_ext` to 0. Otherwise leave the outputs unchanged. No `key_valid` in either case. Clear flags.
- Prefixes may arrive as E0 F0 or F0 E0; both orders give an extended break.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; flags, shift register, watchdog and filter all clear.
  - Filtered clock and synchronisers are 1 (idle-high line).
- Let E be the cycle in which the 11th fall edge (stop bit) is detected. `key_code`, `key_ext` and `key_valid`/`frame_err` are all registered and change on E+1.
- `key_valid` and `frame_err` are exactly 1 cycle wide and never asserted together.
- Input-to-edge latency: 2 sync cycles plus FILTER_LEN cycles after a stable pin level.
- Watchdog abort: `frame_err` is asserted on the cycle after the counter hits TIMEOUT_CYCLES.
- Reset asserted mid-frame: everything returns to reset values immediately. The first frame after release needs a fresh start bit; pending prefixes are lost.
- A fall edge arriving on the same cycle as a watchdog expiry: the abort wins and the edge is dropped.

## Structure
- Package `ps2_pkg`:
  - frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - the ignored-code list (00, AA, EE, FA, FE, FF).
- Sub-module `ps2_line_filter`: synchroniser, FILTER_LEN glitch filter and fall-edge detector. Outputs are the fall-edge pulse and the synchronised data bit.
- The top level holds the frame FSM, the watchdog and the byte decoder.

## Test plan
- Frame 0x1C with correct parity → one `key_valid` pulse on E+1; `key_code`=1C, `key_ext`=0. Then F0 1C → `key_code`=00 with no pulse.
- E0 75, then E0 F0 75 → `key_valid` with `key_code`=75 and `key_ext`=1, then `key_code`=00 and `key_ext`=0. Repeat using F0 E0 75 for the break → same result.
- Make 1C, make 32, break 1C → `key_code` stays 32. Break 32 → `key_code`=00.
- Frame 0x45 with wrong parity bit → `frame_err` pulse; `key_code` unchanged; no `key_valid`. Frame with stop bit 0 → `frame_err`.
- Start bit plus 4 data bits, then clock held high for TIMEOUT_CYCLES → `frame_err` pulse. A following clean 0x16 frame → `key_code`=16 with `key_valid`.
- Glitch of fewer than FILTER_LEN cycles on `ps2c` inside a frame → frame still decodes correctly. `reset` asserted mid-frame → outputs 0 immediately; next full frame 0x1E → `key_code`=1E.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// prefix codes and classification of accepted scan-code bytes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        BYTE_EXT,
        BYTE_BRK,
        BYTE_IGNORED,
        BYTE_KEY
    } byte_class_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Keyboard status/acknowledge replies that never represent a key.
    localparam int NUM_IGNORED = 6;
    localparam logic [NUM_IGNORED-1:0][7:0] IGNORED_CODES = {
        8'hFF, 8'hFE, 8'hFA, 8'hEE, 8'hAA, 8'h00
    };

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORED; i++) begin
            if (code == IGNORED_CODES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic byte_class_t classify(input logic [7:0] code);
        byte_class_t cls;
        if (code == PS2_EXT) begin
            cls = BYTE_EXT;
        end else if (code == PS2_BRK) begin
            cls = BYTE_BRK;
        end else if (is_ignored(code)) begin
            cls = BYTE_IGNORED;
        end else begin
            cls = BYTE_KEY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, debounces the clock with a run-length
// filter and emits a one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          filt;
    logic [CW-1:0] run_cnt;

    // NOTE: synchroniser and filter reset to 1 so an idle-high line produces
    // no spurious edge when reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // run_cnt counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt    <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                filt    <= c_sync[1];
                run_cnt <= '0;
                fall    <= filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign data = d_sync[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frame FSM with watchdog, then a prefix-aware byte
// decoder that tracks the currently held make code.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_ext,
    output logic       frame_err
);

    import ps2_pkg::*;

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data;
    frame_state_t  state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [WW-1:0] wd;
    logic          brk;
    logic          ext;

    logic          timeout;
    logic          stop_edge;
    logic          byte_ok;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk  (clk),
        .reset(reset),
        .ps2c (ps2c),
        .ps2d (ps2d),
        .fall (fall),
        .data (data)
    );

    // An expiring watchdog suppresses any edge that arrives in the same cycle.
    assign timeout   = (state != IDLE) && (wd == WW'(TIMEOUT_CYCLES));
    assign stop_edge = fall && (state == STOP) && !timeout;
    assign byte_ok   = stop_edge && data && (^{shreg, par});

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
            wd        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout || (stop_edge && !byte_ok);
            if (timeout) begin
                state <= IDLE;
                wd    <= '0;
            end else begin
                if (state == IDLE || fall) begin
                    wd <= '0;
                end else begin
                    wd <= wd + 1'b1;
                end
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!data) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {data, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            par   <= data;
                            state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // Byte decoder: consumes shreg in the same cycle the stop bit is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk       <= 1'b0;
            ext       <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_ok) begin
                case (classify(shreg))
                    BYTE_EXT: begin
                        ext <= 1'b1;
                    end
                    BYTE_BRK: begin
                        brk <= 1'b1;
                    end
                    BYTE_IGNORED: begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end
                    default: begin
                        if (!brk) begin
                            key_code  <= shreg;
                            key_ext   <= ext;
                            key_valid <= 1'b1;
                        end else if (shreg == key_code && ext == key_ext) begin
                            key_code <= 8'h00;
                            key_ext  <= 1'b0;
                        end
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: a keyboard-level model predicts
// key_valid/frame_err events and the held key after each byte sequence.
module tb_ps2_keycode_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF           = 20;

    typedef enum int {EV_VALID, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] code;
        logic       ext;
    } event_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ext;
    logic       frame_err;

    ps2_keycode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ext  (key_ext),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    event_t     sb[$];

    // Keyboard-level model: held key plus pending break/extended prefixes.
    logic [7:0] m_code = 8'h00;
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic       m_pre  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit is_ignored_code(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_accept(input logic [7:0] b);
        event_t e;
        if (b == 8'hE0) begin
            m_pre = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!is_ignored_code(b)) begin
                if (!m_brk) begin
                    m_code = b;
                    m_ext  = m_pre;
                    e.kind = EV_VALID;
                    e.code = b;
                    e.ext  = m_pre;
                    sb.push_back(e);
                end else if (b == m_code && m_pre == m_ext) begin
                    m_code = 8'h00;
                    m_ext  = 1'b0;
                end
            end
            m_brk = 1'b0;
            m_pre = 1'b0;
        end
    endtask

    task automatic push_err();
        event_t e;
        e.kind = EV_ERR;
        e.code = m_code;
        e.ext  = m_ext;
        sb.push_back(e);
    endtask

    // Device-side frame: data changes while the clock is high, clock then falls.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            if (i == glitch_bit) begin
                wait_cycles(5);
                ps2c = 1'b0;
                wait_cycles(3);
                ps2c = 1'b1;
                wait_cycles(HALF - 8);
            end else begin
                wait_cycles(HALF);
            end
            ps2c = 1'b0;
            wait_cycles(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_accept(b);
        send_bits(b, 1'b0, 1'b0, 11, -1);
        wait_cycles(2 * HALF);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        push_err();
        send_bits(b, bad_par, bad_stop, 11, -1);
        wait_cycles(2 * HALF);
    endtask

    task automatic check_state(input string name);
        wait_cycles(4);
        check({name, "_code"}, 32'(key_code), 32'(m_code));
        check({name, "_ext"}, 32'(key_ext), 32'(m_ext));
        check({name, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_code"}, 32'(key_code), 32'd0);
        check({name, "_ext"}, 32'(key_ext), 32'd0);
        check({name, "_valid"}, 32'(key_valid), 32'd0);
        check({name, "_err"}, 32'(frame_err), 32'd0);
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    initial begin
        event_t e;
        forever begin
            @(negedge clk);
            if (!reset && (key_valid || frame_err)) begin
                check("valid_err_exclusive", 32'(key_valid & frame_err), 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b code=%0h ext=%0b",
                             key_valid, frame_err, key_code, key_ext);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", 32'(frame_err), (e.kind == EV_ERR) ? 32'd1 : 32'd0);
                    check("event_code", 32'(key_code), 32'(e.code));
                    check("event_ext", 32'(key_ext), 32'(e.ext));
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [6];
        logic [7:0] ign [6];
        logic [7:0] k;
        int         sel;
        bit         bp;
        bit         bs;
        pool = '{8'h1C, 8'h32, 8'h75, 8'h16, 8'h1E, 8'h45};
        ign  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

        wait_cycles(5);
        check_outputs_zero("in_reset");
        reset = 1'b0;
        wait_cycles(20);
        check_outputs_zero("after_reset");

        send_byte(8'h1C);
        check_state("make_1c");
        send_byte(8'hF0); send_byte(8'h1C);
        check_state("break_1c");

        send_byte(8'hE0); send_byte(8'h75);
        check_state("make_e075");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_state("break_e0f075");
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
        check_state("break_f0e075");

        send_byte(8'h1C); send_byte(8'h32);
        send_byte(8'hF0); send_byte(8'h1C);
        check_state("stale_break");
        send_byte(8'hF0); send_byte(8'h32);
        check_state("break_32");

        send_byte(8'h1C);
        send_bad(8'h45, 1'b1, 1'b0);
        check_state("bad_parity");
        send_bad(8'h45, 1'b0, 1'b1);
        check_state("bad_stop");

        push_err();
        send_bits(8'h5A, 1'b0, 1'b0, 5, -1);
        wait_cycles(TIMEOUT_CYCLES + 50);
        check_state("watchdog");
        send_byte(8'h16);
        check_state("after_watchdog");

        model_accept(8'h2B);
        send_bits(8'h2B, 1'b0, 1'b0, 11, 4);
        wait_cycles(2 * HALF);
        check_state("glitch");
        send_byte(8'h2B);
        check_state("typematic");

        send_byte(8'h32);
        send_byte(8'hE0);
        send_bits(8'h1C, 1'b0, 1'b0, 6, -1);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_frame");
        m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_pre = 1'b0;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(20);
        send_byte(8'h1E);
        check_state("after_mid_reset");

        for (int it = 0; it < 30; it++) begin
            sel = int'($urandom_range(0, 9));
            k   = pool[$urandom_range(0, 5)];
            case (sel)
                0, 1, 2, 3: send_byte(k);
                4: begin send_byte(8'hF0); send_byte(k); end
                5: begin send_byte(8'hE0); send_byte(k); end
                6: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(k); end
                7: begin send_byte(8'hF0); send_byte(8'hE0); send_byte(k); end
                8: begin
                    if ($urandom_range(0, 1) == 1) send_byte(8'hE0);
                    send_byte(ign[$urandom_range(0, 5)]);
                end
                default: begin
                    bp = ($urandom_range(0, 1) == 1);
                    bs = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                    send_bad(8'($urandom), bp, bs);
                end
            endcase
            check_state("random");
        end

        wait_cycles(20);
        check("final_pending", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
